// File: rtl/jk_cond_pkg.sv
// Shared types and defaults for the J/K input conditioner.
package jk_cond_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHK_HI    = 2'd1,
    STABLE_HI = 2'd2,
    CHK_LO    = 2'd3
  } db_state_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd1_000_000;
  localparam int unsigned TICK_DIV_DEFAULT        = 32'd134_217_728;

  // Counter width for a terminal count of n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One switch channel: two-flop synchronizer followed by a counter-based debounce FSM.
module debounce_channel
  import jk_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'd1);

  logic          s1_r;
  logic          s2_r;
  db_state_t     state_r;
  db_state_t     state_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_s;
  logic          clean_r;
  logic          clean_s;
  logic          rise_r;
  logic          rise_s;

  // Synchronizer, FSM state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r    <= 1'b0;
      s2_r    <= 1'b0;
      state_r <= STABLE_LO;
      cnt_r   <= {CW{1'b0}};
      clean_r <= 1'b0;
      rise_r  <= 1'b0;
    end else begin
      s1_r    <= raw;
      s2_r    <= s1_r;
      state_r <= state_s;
      cnt_r   <= cnt_s;
      clean_r <= clean_s;
      rise_r  <= rise_s;
    end
  end

  // Next-state logic; a level reversal in a CHK state aborts back to the stable state.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    clean_s = clean_r;
    rise_s  = 1'b0;
    case (state_r)
      STABLE_LO: begin
        if (s2_r) begin
          state_s = CHK_HI;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = STABLE_LO;
        end
      end
      CHK_HI: begin
        if (!s2_r) begin
          state_s = STABLE_LO;
        end else if (cnt_r == CNT_LAST) begin
          state_s = STABLE_HI;
          clean_s = 1'b1;
          rise_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      STABLE_HI: begin
        if (!s2_r) begin
          state_s = CHK_LO;
          cnt_s   = {CW{1'b0}};
        end else begin
          state_s = STABLE_HI;
        end
      end
      CHK_LO: begin
        if (s2_r) begin
          state_s = STABLE_HI;
        end else if (cnt_r == CNT_LAST) begin
          state_s = STABLE_LO;
          clean_s = 1'b0;
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = STABLE_LO;
        cnt_s   = {CW{1'b0}};
        clean_s = 1'b0;
      end
    endcase
  end

  assign clean = clean_r;
  assign rise  = rise_r;

endmodule

// File: rtl/jk_input_conditioner.sv
// Debounces J and K, generates a periodic tick enable and captures clean levels on each tick.
module jk_input_conditioner
  import jk_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned TICK_DIV        = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic j_raw,
  input  logic k_raw,
  output logic j_clean,
  output logic k_clean,
  output logic j_rise,
  output logic k_rise,
  output logic tick,
  output logic j_out,
  output logic k_out
);

  localparam int unsigned TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TICK_DIV - 32'd1);

  logic [TW-1:0] tcnt_r;
  logic          tick_r;
  logic          j_out_r;
  logic          k_out_r;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_j (
    .clk   (clk),
    .rst   (rst),
    .raw   (j_raw),
    .clean (j_clean),
    .rise  (j_rise)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_k (
    .clk   (clk),
    .rst   (rst),
    .raw   (k_raw),
    .clean (k_clean),
    .rise  (k_rise)
  );

  // Free-running divider; tick follows the terminal count by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_r <= {TW{1'b0}};
      tick_r <= 1'b0;
    end else if (tcnt_r == TCNT_LAST) begin
      tcnt_r <= {TW{1'b0}};
      tick_r <= 1'b1;
    end else begin
      tcnt_r <= tcnt_r + TW'(1);
      tick_r <= 1'b0;
    end
  end

  // Output capture, enabled by tick rather than clocked by a divided clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      j_out_r <= 1'b0;
      k_out_r <= 1'b0;
    end else if (tick_r) begin
      j_out_r <= j_clean;
      k_out_r <= k_clean;
    end else begin
      j_out_r <= j_out_r;
      k_out_r <= k_out_r;
    end
  end

  assign tick  = tick_r;
  assign j_out = j_out_r;
  assign k_out = k_out_r;

endmodule

// File: tb/tb_jk_input_conditioner.sv
// Self-checking bench: directed scenarios plus randomized switch activity against a run-length model.
module tb_jk_input_conditioner;

  localparam int D = 4;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic j_raw = 1'b0;
  logic k_raw = 1'b0;
  logic j_clean, k_clean, j_rise, k_rise, tick, j_out, k_out;

  int checks = 0;
  int errors = 0;

  jk_input_conditioner #(.DEBOUNCE_CYCLES(D), .TICK_DIV(T)) dut (
    .clk     (clk),
    .rst     (rst),
    .j_raw   (j_raw),
    .k_raw   (k_raw),
    .j_clean (j_clean),
    .k_clean (k_clean),
    .j_rise  (j_rise),
    .k_rise  (k_rise),
    .tick    (tick),
    .j_out   (j_out),
    .k_out   (k_out)
  );

  always #5 clk = ~clk;

  // Reference: clean flips once the synchronized level has disagreed with it
  // for D+1 consecutive samples; tick after every T-th edge since reset.
  bit m_s1[2], m_s2[2], m_clean[2], m_rise[2];
  int m_run[2];
  int m_edges;
  bit m_tick, m_jo, m_ko;

  task automatic model_edge(input bit j, input bit k, input bit r);
    bit raw[2];
    raw[0] = j;
    raw[1] = k;
    if (r) begin
      for (int c = 0; c < 2; c++) begin
        m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_clean[c] = 1'b0; m_rise[c] = 1'b0; m_run[c] = 0;
      end
      m_edges = 0; m_tick = 1'b0; m_jo = 1'b0; m_ko = 1'b0;
    end else begin
      if (m_tick) begin
        m_jo = m_clean[0];
        m_ko = m_clean[1];
      end
      for (int c = 0; c < 2; c++) begin
        m_rise[c] = 1'b0;
        if (m_s2[c] != m_clean[c]) begin
          m_run[c]++;
          if (m_run[c] == D + 1) begin
            m_clean[c] = m_s2[c];
            m_rise[c]  = m_s2[c];
            m_run[c]   = 0;
          end
        end else begin
          m_run[c] = 0;
        end
        m_s2[c] = m_s1[c];
        m_s1[c] = raw[c];
      end
      m_edges++;
      m_tick = (m_edges % T) == 0;
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check_bit("j_clean", j_clean, m_clean[0]);
    check_bit("k_clean", k_clean, m_clean[1]);
    check_bit("j_rise", j_rise, m_rise[0]);
    check_bit("k_rise", k_rise, m_rise[1]);
    check_bit("tick", tick, m_tick);
    check_bit("j_out", j_out, m_jo);
    check_bit("k_out", k_out, m_ko);
  endtask

  task automatic step(input bit j, input bit k, input bit r);
    j_raw = j;
    k_raw = k;
    rst   = r;
    @(posedge clk);
    model_edge(j, k, r);
    #1;
    check_all();
  endtask

  int lat_j, lat_k, first_tick, jr_cnt;
  bit seen;
  int hold;
  bit rj, rk;

  initial begin
    // Reset held 3 cycles with both switches high.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
    lat_j = -1; first_tick = -1;
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (j_clean === 1'b1 && lat_j < 0) lat_j = i;
      if (tick === 1'b1 && first_tick < 0) first_tick = i;
    end
    check_int("reset_release_j_latency", lat_j, D + 3);
    check_int("first_tick_edge", first_tick, T);

    // Clean rise on J only; K stays low.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b0, 1'b0);
    lat_j = -1; jr_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (j_clean === 1'b1 && lat_j < 0) lat_j = i;
      if (j_rise === 1'b1) jr_cnt++;
    end
    check_int("j_rise_latency", lat_j, D + 3);
    check_int("j_rise_pulse_count", jr_cnt, 1);
    check_bit("k_clean_idle", k_clean, 1'b0);

    // Glitch on K shorter than the debounce window.
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k_clean === 1'b1 || k_rise === 1'b1) seen = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k_clean === 1'b1 || k_rise === 1'b1) seen = 1'b1;
    end
    check_bit("glitch_rejected", seen, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < D + 1; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (k_clean === 1'b1) seen = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (k_clean === 1'b1) seen = 1'b1;
    end
    check_bit("long_pulse_accepted", seen, 1'b1);

    // Tick cadence with random J activity.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3 * T + 2; i++) step(1'($urandom_range(1, 0)), 1'b0, 1'b0);

    // Simultaneous rise on both channels.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
    lat_j = -1; lat_k = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (j_rise === 1'b1) lat_j = i;
      if (k_rise === 1'b1) lat_k = i;
    end
    check_int("simultaneous_rise_j", lat_j, D + 3);
    check_int("simultaneous_rise_k", lat_k, lat_j);

    // Drop both, reset in the middle of the low check, then re-rise.
    for (int i = 0; i < 10 && m_run[0] != 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    lat_j = -1; lat_k = -1;
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (j_clean === 1'b1 && lat_j < 0) lat_j = i;
      if (k_clean === 1'b1 && lat_k < 0) lat_k = i;
    end
    check_int("mid_reset_rerise_j", lat_j, D + 3);
    check_int("mid_reset_rerise_k", lat_k, D + 3);

    // Randomized bursts of varying length with occasional reset.
    for (int b = 0; b < 150; b++) begin
      rj = 1'($urandom_range(1, 0));
      rk = 1'($urandom_range(1, 0));
      hold = $urandom_range(D + 3, 1);
      for (int i = 0; i < hold; i++) step(rj, rk, ($urandom_range(60, 0) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
